mfp_ahb_cmd_master: RTL

Single-transfer AHB-Lite initiator. It turns a simple valid/ready command (read/write, address, data) into one AHB-Lite NONSEQ transfer toward the GPIO and other MFP slaves. It returns the read data and error status on a one-cycle response strobe. It is the bus-master counterpart to the memory-mapped slaves and lets hardware engines (bot sequencer, accelerometer poller) reach registers without the CPU.

---
 rtl/mfp_ahb_cmd_master.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/mfp_ahb_cmd_master.sv
// mfp_ahb_cmd_master: single-transfer AHB-Lite initiator.
// Turns one valid/ready command into one NONSEQ SINGLE transfer and returns
// read data / error status on a one-cycle response strobe.
// Optional build macro MFP_AHB_CMD_MASTER_TIMEOUT_EN adds an HREADY-low
// watchdog that aborts a stalled transfer after TIMEOUT_CYCLES.
//
// Handshake: a command transfers on a rising HCLK edge where cmd_valid and
// cmd_ready are both 1; cmd_ready is high only in IDLE, and command inputs
// are ignored otherwise. rsp_valid is a one-cycle strobe with no
// backpressure; rsp_rdata/rsp_err/rsp_timeout hold until the next response.
module mfp_ahb_cmd_master #(
  parameter int         TIMEOUT_CYCLES = 255,
  parameter logic [3:0] HPROT_VAL      = 4'b0011
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [1:0]  cmd_size,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        rsp_timeout,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [3:0]  HPROT,
  output logic        HMASTLOCK,
  output logic [31:0] HWDATA,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic        HRESP
);

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_RESP} state_t;

  state_t      r_state;
  logic        r_cmd_ready;
  logic        r_rsp_valid;
  logic [31:0] r_rsp_rdata;
  logic        r_rsp_err;
  logic [31:0] r_haddr;
  logic [1:0]  r_htrans;
  logic        r_hwrite;
  logic [2:0]  r_hsize;
  logic [31:0] r_hwdata;
  logic [31:0] r_wdata;
  logic [1:0]  w_size;
  logic        w_abort;

  // Size code 3 has no meaning for this bus; fold it onto word.
  assign w_size = (cmd_size == 2'd3) ? 2'd2 : cmd_size;

`ifdef MFP_AHB_CMD_MASTER_TIMEOUT_EN
  localparam int CW_RAW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CW     = (CW_RAW > 8) ? CW_RAW : 8;

  logic [CW-1:0] r_wd_cnt;
  logic          r_rsp_timeout;

  // Abort on the HREADY-low cycle that brings the count to TIMEOUT_CYCLES.
  assign w_abort     = !HREADY && (r_wd_cnt == CW'(TIMEOUT_CYCLES - 1));
  assign rsp_timeout = r_rsp_timeout;

  // Watchdog: cleared on ADDR entry, counts HREADY-low cycles in ADDR/DATA.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_wd_cnt      <= '0;
      r_rsp_timeout <= 1'b0;
    end else begin
      if (r_state == S_IDLE) begin
        r_wd_cnt <= '0;
      end else if ((r_state == S_ADDR || r_state == S_DATA) && !HREADY) begin
        r_wd_cnt <= r_wd_cnt + 1'b1;
      end
      if (r_state == S_ADDR || r_state == S_DATA) begin
        if (w_abort) begin
          r_rsp_timeout <= 1'b1;
        end else if (HREADY && r_state == S_DATA) begin
          r_rsp_timeout <= 1'b0;
        end
      end
    end
  end
`else
  logic w_unused_timeout;

  // Without the watchdog the transfer waits for HREADY indefinitely.
  assign w_abort          = 1'b0;
  assign rsp_timeout      = 1'b0;
  assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

  // Main transfer sequencer: IDLE -> ADDR -> DATA -> RESP -> IDLE.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_state     <= S_IDLE;
      r_cmd_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      r_haddr     <= '0;
      r_htrans    <= TR_IDLE;
      r_hwrite    <= 1'b0;
      r_hsize     <= '0;
      r_hwdata    <= '0;
      r_wdata     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cmd_ready <= 1'b1;
          if (cmd_valid && r_cmd_ready) begin
            r_wdata     <= cmd_wdata;
            r_haddr     <= cmd_addr;
            r_hwrite    <= cmd_write;
            r_hsize     <= {1'b0, w_size};
            r_htrans    <= TR_NONSEQ;
            r_cmd_ready <= 1'b0;
            r_state     <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (w_abort) begin
            r_htrans    <= TR_IDLE;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b1;
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESP;
          end else if (HREADY) begin
            r_htrans <= TR_IDLE;
            if (r_hwrite) begin
              r_hwdata <= r_wdata;
            end
            r_state <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_abort) begin
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b1;
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESP;
          end else if (HREADY) begin
            r_rsp_rdata <= r_hwrite ? 32'd0 : HRDATA;
            r_rsp_err   <= HRESP;
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESP;
          end
        end
        default: begin
          r_rsp_valid <= 1'b0;
          r_cmd_ready <= 1'b1;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready = r_cmd_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;
  assign HADDR     = r_haddr;
  assign HTRANS    = r_htrans;
  assign HWRITE    = r_hwrite;
  assign HSIZE     = r_hsize;
  assign HBURST    = 3'b000;
  assign HPROT     = HPROT_VAL;
  assign HMASTLOCK = 1'b0;
  assign HWDATA    = r_hwdata;

endmodule
